// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Round-robin arbiter and sequencer for the single shared 32-bit memory port.
// Requester A is instruction fetch, requester B is the load/store unit. One
// requester wins per transaction. Its address, write data and write enable are
// registered toward memory and held until MemAck arrives or the wait counter
// expires. The winner then gets a one-cycle DoneX (or ErrX) pulse.
//
// Handshake: ReqX is a level that the requester holds until it sees DoneX or
// ErrX. The block answers every granted request with exactly one of those
// pulses, unless reset intervenes. The DONE state ignores all requests for one
// cycle so the finishing requester can drop ReqX. On the memory side, MemReq
// stays high for the whole transaction. MemAck is a single-cycle strobe that
// counts only while a grant is active.
//
// Parameters:
//   TIMEOUT    cycles of MemReq without MemAck before aborting (1..255)
// Ports:
//   Clk, Rst_n            clock, synchronous active-low reset
//   ReqA/ReqB             request levels
//   AddrA/AddrB           request addresses
//   WrA/WrB               1 = write, 0 = read
//   WrDataA/WrDataB       write data
//   MemAck, MemRdData     memory completion strobe and read data
//   Sel                   shared 2:1 mux select (0 = A, 1 = B)
//   MemReq, MemWr         registered transaction-active and write enable
//   MemAddr, MemWrData    registered address and write data
//   RdData                captured read data, held between transactions
//   DoneA/DoneB           one-cycle completion pulses
//   ErrA/ErrB             one-cycle timeout pulses
//   Busy                  high in every state other than IDLE
//   DbgState              current FSM state (0 IDLE, 1 GNT_A, 2 GNT_B, 3 DONE)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        ReqA,
    input  logic        ReqB,
    input  logic [31:0] AddrA,
    input  logic [31:0] AddrB,
    input  logic        WrA,
    input  logic        WrB,
    input  logic [31:0] WrDataA,
    input  logic [31:0] WrDataB,
    input  logic        MemAck,
    input  logic [31:0] MemRdData,
    output logic        Sel,
    output logic        MemReq,
    output logic        MemWr,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWrData,
    output logic [31:0] RdData,
    output logic        DoneA,
    output logic        DoneB,
    output logic        ErrA,
    output logic        ErrB,
    output logic        Busy,
    output logic [1:0]  DbgState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Last wait-counter value before aborting: MemReq is then high for
    // exactly TIMEOUT cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       last_gnt;   // 0 = A won last, 1 = B won last
    logic [7:0] wait_cnt;
    logic       pick_b;

    // B wins when it is the only requester, or on a tie when A won last.
    assign pick_b   = ReqB & (~ReqA | ~last_gnt);
    assign DbgState = state;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;  // A wins the first tie
            wait_cnt  <= 8'd0;
            Sel       <= 1'b0;
            MemReq    <= 1'b0;
            MemWr     <= 1'b0;
            MemAddr   <= 32'h0;
            MemWrData <= 32'h0;
            RdData    <= 32'h0;
            DoneA     <= 1'b0;
            DoneB     <= 1'b0;
            ErrA      <= 1'b0;
            ErrB      <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            // Completion/error strobes last one cycle unless set below.
            DoneA <= 1'b0;
            DoneB <= 1'b0;
            ErrA  <= 1'b0;
            ErrB  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ReqA || ReqB) begin
                        state     <= pick_b ? GNT_B : GNT_A;
                        Sel       <= pick_b;
                        MemAddr   <= pick_b ? AddrB   : AddrA;
                        MemWrData <= pick_b ? WrDataB : WrDataA;
                        MemWr     <= pick_b ? WrB     : WrA;
                        MemReq    <= 1'b1;
                        last_gnt  <= pick_b;
                        wait_cnt  <= 8'd0;
                        Busy      <= 1'b1;
                    end
                end
                GNT_A, GNT_B: begin
                    // An ack on the last allowed cycle still completes normally.
                    if (MemAck) begin
                        state  <= DONE;
                        MemReq <= 1'b0;
                        if (!MemWr) begin
                            RdData <= MemRdData;
                        end
                        DoneA <= (state == GNT_A);
                        DoneB <= (state == GNT_B);
                    end else if (wait_cnt == WAIT_LAST) begin
                        state  <= DONE;
                        MemReq <= 1'b0;
                        ErrA   <= (state == GNT_A);
                        ErrB   <= (state == GNT_B);
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with TIMEOUT = 4. Inputs are driven 1ns
// after the rising edge and outputs are checked at the same point, so each
// check sees the registers updated by the preceding edge. Memory can answer
// automatically (zero-wait: MemAck mirrors MemReq) or under manual control.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        Clk;
    logic        Rst_n;
    logic        ReqA, ReqB;
    logic [31:0] AddrA, AddrB;
    logic        WrA, WrB;
    logic [31:0] WrDataA, WrDataB;
    logic        MemAck;
    logic [31:0] MemRdData;
    logic        Sel, MemReq, MemWr;
    logic [31:0] MemAddr, MemWrData, RdData;
    logic        DoneA, DoneB, ErrA, ErrB, Busy;
    logic [1:0]  DbgState;

    logic        ack_auto;
    logic        ack_man;

    int n_checks;
    int n_fails;

    // Pulse counters sampled on the falling edge.
    int done_a_cnt, done_b_cnt, err_a_cnt, err_b_cnt;

    // Expected grant order (Sel values) for the tie sequence.
    logic [0:0] exp_q[$];

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .ReqA      (ReqA),
        .ReqB      (ReqB),
        .AddrA     (AddrA),
        .AddrB     (AddrB),
        .WrA       (WrA),
        .WrB       (WrB),
        .WrDataA   (WrDataA),
        .WrDataB   (WrDataB),
        .MemAck    (MemAck),
        .MemRdData (MemRdData),
        .Sel       (Sel),
        .MemReq    (MemReq),
        .MemWr     (MemWr),
        .MemAddr   (MemAddr),
        .MemWrData (MemWrData),
        .RdData    (RdData),
        .DoneA     (DoneA),
        .DoneB     (DoneB),
        .ErrA      (ErrA),
        .ErrB      (ErrB),
        .Busy      (Busy),
        .DbgState  (DbgState)
    );

    assign MemAck = ack_auto ? MemReq : ack_man;

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (DoneA) done_a_cnt++;
        if (DoneB) done_b_cnt++;
        if (ErrA)  err_a_cnt++;
        if (ErrB)  err_b_cnt++;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        tick();
        tick();
        Rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        ReqA = 0; ReqB = 0; WrA = 0; WrB = 0;
        AddrA = 0; AddrB = 0; WrDataA = 0; WrDataB = 0;
        MemRdData = 0; ack_auto = 0; ack_man = 0;
    endtask

    // ---------------- stimulus ----------------
    int         mreq_cycles;
    int         snap;
    logic [31:0] exp_rd;
    logic [0:0]  exp_sel;

    initial begin
        n_checks = 0; n_fails = 0;
        done_a_cnt = 0; done_b_cnt = 0; err_a_cnt = 0; err_b_cnt = 0;
        idle_inputs();
        Rst_n = 1'b0;
        tick();

        // ---- reset state ----
        do_reset();
        check("rst_sel",    {31'd0, Sel},    32'd0);
        check("rst_memreq", {31'd0, MemReq}, 32'd0);
        check("rst_memwr",  {31'd0, MemWr},  32'd0);
        check("rst_busy",   {31'd0, Busy},   32'd0);
        check("rst_addr",   MemAddr,   32'h0);
        check("rst_wdata",  MemWrData, 32'h0);
        check("rst_rddata", RdData,    32'h0);
        check("rst_state",  {30'd0, DbgState}, 32'd0);
        check("rst_pulses", {28'd0, DoneA, DoneB, ErrA, ErrB}, 32'd0);

        // ---- single read by A, ack on 3rd MemReq cycle ----
        snap = done_a_cnt;
        ReqA = 1; AddrA = 32'h0000_0040; WrA = 0;
        tick();  // grant edge
        check("rd_sel",    {31'd0, Sel},    32'd0);
        check("rd_addr",   MemAddr,          32'h40);
        check("rd_memreq", {31'd0, MemReq}, 32'd1);
        check("rd_busy",   {31'd0, Busy},   32'd1);
        check("rd_state",  {30'd0, DbgState}, 32'd1);
        mreq_cycles = 1;
        tick();
        if (MemReq) mreq_cycles++;
        tick();
        if (MemReq) mreq_cycles++;
        ack_man = 1; MemRdData = 32'hDEAD_BEEF;
        tick();  // ack sampled
        if (MemReq) mreq_cycles++;
        ack_man = 0; ReqA = 0; MemRdData = 32'h0;
        check("rd_mreq_cycles", mreq_cycles, 32'd3);
        check("rd_donea",  {31'd0, DoneA},  32'd1);
        check("rd_rddata", RdData, 32'hDEAD_BEEF);
        tick();
        check("rd_donea_clr", {31'd0, DoneA}, 32'd0);
        check("rd_idle_busy", {31'd0, Busy},  32'd0);
        check("rd_donea_once", done_a_cnt - snap, 32'd1);
        exp_rd = 32'hDEAD_BEEF;

        // ---- MemAck in IDLE is ignored ----
        ack_man = 1; MemRdData = 32'h5555_AAAA;
        tick();
        ack_man = 0;
        tick();
        check("idle_ack_rddata", RdData, exp_rd);
        check("idle_ack_memreq", {31'd0, MemReq}, 32'd0);
        check("idle_ack_state",  {30'd0, DbgState}, 32'd0);

        // ---- tie from reset: A, B, A, B ----
        do_reset();
        exp_rd = 32'h0;
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        AddrA = 32'hA000_0000; AddrB = 32'hB000_0000;
        ReqA = 1; ReqB = 1; ack_auto = 1;
        for (int i = 0; i < 4; i++) begin
            MemRdData = 32'hA5A5_0000 + i;
            exp_sel = exp_q.pop_front();
            tick();  // grant edge
            check($sformatf("tie%0d_sel", i), {31'd0, Sel}, {31'd0, exp_sel});
            check($sformatf("tie%0d_memreq", i), {31'd0, MemReq}, 32'd1);
            check($sformatf("tie%0d_addr", i), MemAddr, exp_sel ? 32'hB000_0000 : 32'hA000_0000);
            tick();  // zero-wait ack sampled
            check($sformatf("tie%0d_done", i), {30'd0, DoneA, DoneB},
                  exp_sel ? 32'd1 : 32'd2);
            check($sformatf("tie%0d_rddata", i), RdData, 32'hA5A5_0000 + i);
            if (i == 3) begin
                ReqA = 0; ReqB = 0;
            end
            tick();  // DONE -> IDLE
            check($sformatf("tie%0d_idle", i), {31'd0, MemReq}, 32'd0);
        end
        exp_rd = 32'hA5A5_0003;
        tick();
        check("tie_end_state", {30'd0, DbgState}, 32'd0);

        // ---- write by B ----
        snap = done_b_cnt;
        ReqB = 1; WrB = 1; WrDataB = 32'h1234_5678; AddrB = 32'h100;
        AddrA = 32'hFFFF_0000; WrDataA = 32'h0BAD_0BAD; WrA = 0;
        MemRdData = 32'hBAD0_0000;
        ack_auto = 0;
        tick();
        AddrA = 32'hEEEE_0000;  // loser input changes mid-grant
        check("wr_sel",   {31'd0, Sel},   32'd1);
        check("wr_memwr", {31'd0, MemWr}, 32'd1);
        check("wr_wdata", MemWrData, 32'h1234_5678);
        check("wr_addr",  MemAddr,   32'h100);
        ack_man = 1;
        tick();
        ack_man = 0; ReqB = 0; WrB = 0;
        check("wr_doneb",  {31'd0, DoneB}, 32'd1);
        check("wr_rddata", RdData, exp_rd);
        check("wr_addr_hold", MemAddr, 32'h100);
        tick();
        check("wr_doneb_once", done_b_cnt - snap, 32'd1);

        // ---- timeout on A, no MemAck ----
        snap = err_a_cnt;
        begin
            int dsnap;
            dsnap = done_a_cnt;
            ReqA = 1; AddrA = 32'h200; WrA = 0;
            MemRdData = 32'h7777_7777;
            tick();
            mreq_cycles = 0;
            if (MemReq) mreq_cycles = 1;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (!MemReq) break;
                mreq_cycles++;
            end
            check("to_mreq_cycles", mreq_cycles, 32'd4);
            check("to_erra",   {31'd0, ErrA},  32'd1);
            check("to_donea",  {31'd0, DoneA}, 32'd0);
            check("to_rddata", RdData, exp_rd);
            ReqA = 0;
            tick();
            check("to_erra_clr", {31'd0, ErrA}, 32'd0);
            check("to_state",    {30'd0, DbgState}, 32'd0);
            check("to_erra_once", err_a_cnt - snap, 32'd1);
            check("to_no_donea",  done_a_cnt - dsnap, 32'd0);
        end

        // ---- MemAck on the cycle the timeout would fire (B) ----
        snap = err_b_cnt;
        ReqB = 1; AddrB = 32'h300; WrB = 0;
        tick();  // grant, wait_cnt 0
        tick();
        tick();
        tick();  // 4th MemReq cycle now
        check("race_memreq", {31'd0, MemReq}, 32'd1);
        ack_man = 1; MemRdData = 32'h600D_F00D;
        tick();
        ack_man = 0; ReqB = 0;
        check("race_doneb",  {31'd0, DoneB}, 32'd1);
        check("race_errb",   {31'd0, ErrB},  32'd0);
        check("race_rddata", RdData, 32'h600D_F00D);
        tick();
        check("race_no_errb", err_b_cnt - snap, 32'd0);

        // ---- reset during GNT_B ----
        ReqA = 1; AddrA = 32'h400;
        tick();  // A granted (last was B), gives B the next tie
        ack_man = 1;
        tick();
        ack_man = 0; ReqA = 0;
        tick();
        snap = done_b_cnt + err_b_cnt;
        ReqB = 1; AddrB = 32'h500;
        tick();
        check("rg_sel_b", {31'd0, Sel}, 32'd1);
        Rst_n = 0;
        tick();
        Rst_n = 1; ReqB = 0;
        check("rg_memreq", {31'd0, MemReq}, 32'd0);
        check("rg_sel",    {31'd0, Sel},    32'd0);
        check("rg_rddata", RdData, 32'h0);
        tick();
        tick();
        check("rg_no_pulse", done_b_cnt + err_b_cnt - snap, 32'd0);
        ReqA = 1; ReqB = 1; AddrA = 32'h600; AddrB = 32'h700;
        tick();
        check("rg_tie_sel",  {31'd0, Sel}, 32'd0);
        check("rg_tie_addr", MemAddr, 32'h600);
        ReqA = 0; ReqB = 0;
        ack_man = 1;
        tick();
        ack_man = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter and sequencer for the datapath's single shared 32-bit memory port, which serves requester A (instruction fetch) and requester B (load/store unit). The block picks one requester per transaction and drives the `Sel` line of the 32-bit 2:1 operand multiplexer (0 = A, 1 = B). It registers the winning address and write data toward memory and holds them until the memory acknowledges or a timeout expires. It then returns read data and a one-cycle completion pulse to the winner.

## Interface
- `TIMEOUT`, 16: cycles to wait for `MemAck` after `MemReq` rises before aborting; legal range 1–255.
- `Clk` input 1: rising-edge clock; the only clock.
- `Rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `Clk`.
- `ReqA` / `ReqB` input 1: request level; held high until the matching `DoneX` or `ErrX` pulse.
- `AddrA` / `AddrB` input 32: request address; stable while `ReqX` is high.
- `WrA` / `WrB` input 1: 1 = write, 0 = read.
- `WrDataA` / `WrDataB` input 32: write data.
- `MemAck` input 1: one-cycle completion strobe from memory.
- `MemRdData` input 32: read data; valid in the `MemAck` cycle.
- `Sel` output 1: select to the shared 2:1 mux; 0 = A, 1 = B.
- `MemReq` output 1: memory transaction active.
- `MemWr` output 1: registered write enable.
- `MemAddr` output 32: registered address.
- `MemWrData` output 32: registered write data.
- `RdData` output 32: captured read data; holds its value between transactions.
- `DoneA` / `DoneB` output 1: one-cycle completion pulse.
- `ErrA` / `ErrB` output 1: one-cycle timeout pulse.
- `Busy` output 1: high in every state other than IDLE.

## Operation
- States: IDLE, GNT_A, GNT_B, DONE.
- IDLE, arbitration:
  - If only one `ReqX` is high, that requester wins.
  - If both are high, the requester not recorded in `LastGnt` wins.
  - If neither is high, stay in IDLE.
- IDLE → GNT_X on the winning edge. On that same edge:
  - `Sel` takes the winner's value.
  - `MemAddr`, `MemWrData` and `MemWr` capture the winner's inputs.
  - `MemReq` is set to 1.
  - `LastGnt` records the winner.
  - The wait counter clears.
- GNT_X, `MemAck` sampled high → DONE:
  - `MemReq` goes to 0.
  - `DoneX` is 1 for the next cycle.
  - If `MemWr` = 0, `RdData` captures `MemRdData`; a write leaves `RdData` unchanged.
- GNT_X, `MemAck` sampled low: the wait counter increments. When the counter reaches `TIMEOUT - 1` while `MemAck` is still low:
  - Go to DONE with `MemReq` = 0 and `ErrX` = 1 for one cycle.
  - `RdData` is unchanged.
- If `MemAck` is high on the cycle the timeout would fire, `MemAck` wins and the transaction completes normally.
- DONE → IDLE unconditionally after one cycle.
  - All requests are ignored in DONE, so the finishing requester has one cycle to drop `ReqX`.
- `MemAck` arriving in IDLE or DONE is ignored; no output changes.
- `Sel`, `MemAddr`, `MemWrData` and `MemWr` hold their last values outside GNT states. `Sel` never changes while `MemReq` = 1.
- A requester that drops `ReqX` mid-grant does not abort the transaction; it still receives `DoneX` or `ErrX`.
- Changes on the losing requester's inputs do not affect the active transaction.

## Timing
- Reset (`Rst_n` = 0 at an edge):
  - State → IDLE.
  - `Sel`, `MemReq`, `MemWr`, `Busy`, `DoneA`, `DoneB`, `ErrA`, `ErrB` → 0.
  - `MemAddr`, `MemWrData`, `RdData` → 32'h0.
  - `LastGnt` → B, so A wins the first tie.
  - Reset mid-transaction aborts silently: no `DoneX` and no `ErrX`.
- Latency, counted from the edge that samples `ReqX` high in IDLE:
  - `MemReq` is high on the following cycle.
  - With zero-wait memory (`MemAck` high in the first `MemReq` cycle), `DoneX` is high 2 cycles after the request edge.
  - Minimum spacing between grants is 3 cycles (GNT, DONE, IDLE).
- Timeout: `MemReq` is high for exactly `TIMEOUT` cycles, then `ErrX` pulses on the next cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset then a single read:
  - Stimulus: `ReqA` = 1, `AddrA` = 32'h0000_0040; `MemAck` = 1 on the 3rd `MemReq` cycle with `MemRdData` = 32'hDEAD_BEEF.
  - Required: `Sel` = 0, `MemAddr` = 32'h40, `MemReq` high for 3 cycles, `DoneA` pulses once, `RdData` = 32'hDEAD_BEEF.
- Tie from reset:
  - Stimulus: `ReqA` and `ReqB` both held high with zero-wait `MemAck`.
  - Required grants A, B, A, B; `Sel` toggles 0, 1, 0, 1; each grant starts 3 cycles after the previous one.
- Write by B:
  - Stimulus: `WrB` = 1, `WrDataB` = 32'h1234_5678, `AddrB` = 32'h100.
  - Required: `MemWr` = 1, `MemWrData` = 32'h1234_5678, `Sel` = 1, `DoneB` pulses, `RdData` unchanged.
- Timeout with `TIMEOUT` = 4 and no `MemAck`:
  - Required: `MemReq` high for exactly 4 cycles, `ErrA` pulses for 1 cycle, no `DoneA`, state returns to IDLE.
- `MemAck` on the same cycle the timeout would fire:
  - Required: `DoneX` pulses and `ErrX` stays 0.
- `Rst_n` = 0 during GNT_B:
  - Required: next cycle `MemReq` = 0, `Sel` = 0, no `DoneB` or `ErrB`; a subsequent A/B tie grants A.
